// File: rtl/biu_pkg.sv
// biu_pkg: types shared by the multi-master BIU arbiter blocks.
package biu_pkg;
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} biu_arb_state_t;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick, searching req upward from ptr with wrap.
module rr_arbiter #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] idx,
    output logic          any_req
);
    always_comb begin
        idx = '0;
        // walk offsets from farthest to nearest so the closest requester to ptr wins
        for (int i = N - 1; i >= 0; i--)
            if (req[(int'(ptr) + i) % N]) idx = IW'((int'(ptr) + i) % N);
        any_req = |req;
        gnt = any_req ? N'(1) << idx : '0;
    end
endmodule

// File: rtl/biu_rr_arbiter.sv
// biu_rr_arbiter: round-robin arbitration of NUM_MASTERS BIU channels onto one slave, one transaction in flight.
// Defining BIU_ARB_TIMEOUT_EN aborts a WAIT after TIMEOUT_CYCLES and returns all-ones data.
module biu_rr_arbiter
    import biu_pkg::*;
#(
    parameter int NUM_MASTERS    = 4,
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                              clk,
    input  logic                              n_rst,
    input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] m_address,
    input  logic [NUM_MASTERS*DATA_WIDTH-1:0] m_data_out,
    input  logic [NUM_MASTERS-1:0]            m_rnw,
    input  logic [NUM_MASTERS-1:0]            m_en,
    output logic [NUM_MASTERS*DATA_WIDTH-1:0] m_data_in,
    output logic [NUM_MASTERS-1:0]            m_data_valid,
    output logic [NUM_MASTERS-1:0]            m_busy,
    output logic [ADDR_WIDTH-1:0]             s_address,
    output logic [DATA_WIDTH-1:0]             s_data_out,
    output logic                              s_rnw,
    output logic                              s_en,
    input  logic [DATA_WIDTH-1:0]             s_data_in,
    input  logic                              s_data_valid
);
    localparam int IW = $clog2(NUM_MASTERS);

    biu_arb_state_t         state, state_nx;
    logic [IW-1:0]          ptr, gnt_idx, arb_idx;
    logic [NUM_MASTERS-1:0] gnt_oh, arb_oh;
    logic                   any_req, done_go;
    logic [DATA_WIDTH-1:0]  ret_data;

    rr_arbiter #(.N(NUM_MASTERS), .IW(IW)) u_rr (
        .req(m_en), .ptr(ptr), .gnt(arb_oh), .idx(arb_idx), .any_req(any_req)
    );

`ifdef BIU_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] wait_cnt;
    logic          timed_out;
    always_ff @(posedge clk or negedge n_rst)
        if (!n_rst) wait_cnt <= '0;
        else wait_cnt <= state == WAIT ? wait_cnt + 1'b1 : '0;
    assign timed_out = state == WAIT && wait_cnt == CW'(TIMEOUT_CYCLES - 1);
    // a real response on the timeout cycle still wins
    assign done_go  = s_data_valid || timed_out;
    assign ret_data = s_data_valid ? s_data_in : {DATA_WIDTH{1'b1}};
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT_CYCLES;
    assign done_go  = s_data_valid;
    assign ret_data = s_data_in;
`endif

    always_comb begin
        state_nx = state;
        if (state == IDLE && any_req) state_nx = ISSUE;
        if (state == ISSUE) state_nx = WAIT;
        if (state == WAIT && done_go) state_nx = DONE;
        if (state == DONE) state_nx = IDLE;
    end

    assign s_en         = state == ISSUE;
    assign m_busy       = {NUM_MASTERS{state != IDLE}};
    assign m_data_valid = state == DONE ? gnt_oh : '0;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state      <= IDLE;
            ptr        <= '0;
            gnt_idx    <= '0;
            gnt_oh     <= '0;
            s_address  <= '0;
            s_data_out <= '0;
            s_rnw      <= 1'b0;
            m_data_in  <= '0;
        end else begin
            state <= state_nx;
            if (state == IDLE && any_req) begin
                gnt_idx    <= arb_idx;
                gnt_oh     <= arb_oh;
                s_address  <= m_address[arb_idx*ADDR_WIDTH +: ADDR_WIDTH];
                s_data_out <= m_data_out[arb_idx*DATA_WIDTH +: DATA_WIDTH];
                s_rnw      <= m_rnw[arb_idx];
            end
            if (state == WAIT && done_go) m_data_in[gnt_idx*DATA_WIDTH +: DATA_WIDTH] <= ret_data;
            if (state == DONE) ptr <= gnt_idx == IW'(NUM_MASTERS - 1) ? '0 : gnt_idx + 1'b1;
        end
    end
endmodule

// File: tb/tb_biu_rr_arbiter.sv
// tb_biu_rr_arbiter: scoreboard bench for biu_rr_arbiter with a behavioural grant/slave model.
module tb_biu_rr_arbiter;
    localparam int N  = 4;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 8;
`ifdef BIU_ARB_TIMEOUT_EN
    localparam int LONG_DLY = TO - 2;
`else
    localparam int LONG_DLY = 10;
`endif

    logic          clk = 1'b0, n_rst = 1'b1;
    logic [N*AW-1:0] m_address = '0;
    logic [N*DW-1:0] m_data_out = '0;
    logic [N-1:0]  m_rnw = '0, m_en = '0;
    logic [N*DW-1:0] m_data_in;
    logic [N-1:0]  m_data_valid, m_busy;
    logic [AW-1:0] s_address;
    logic [DW-1:0] s_data_out;
    logic          s_rnw, s_en;
    logic [DW-1:0] s_data_in = '0;
    logic          s_data_valid = 1'b0;

    typedef struct {int idx; logic [DW-1:0] data; int lat;} exp_t;
    exp_t          sb[$];
    int            issue_log[$];
    logic [DW-1:0] dout_log[$];
    logic [DW-1:0] model_data[N];
    int            checks = 0, errors = 0, cyc = 0, iss_cyc = 0, done_cnt = 0, mptr = 0;
    int            fix_delay = -1, cur_lat = 0, sl_cnt = 0;
    logic [N-1:0]  en_prev = '0;
    bit            inflight = 0, silent = 0, spur = 0, fix_data = 0, rand_req = 0, sl_pending = 0;
    logic [AW-1:0] iss_addr = '0;
    logic [DW-1:0] iss_dout = '0, fixed_val = '0, cur_resp = '0;
    logic          iss_rnw = 1'b0;

    biu_rr_arbiter #(.NUM_MASTERS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .n_rst(n_rst), .m_address(m_address), .m_data_out(m_data_out), .m_rnw(m_rnw),
        .m_en(m_en), .m_data_in(m_data_in), .m_data_valid(m_data_valid), .m_busy(m_busy),
        .s_address(s_address), .s_data_out(s_data_out), .s_rnw(s_rnw), .s_en(s_en),
        .s_data_in(s_data_in), .s_data_valid(s_data_valid)
    );

    always #5 clk = ~clk;

    function automatic void chk(string nm, logic [255:0] act, logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endfunction

    // requester whose distance above ptr (mod N) is smallest
    function automatic int rr_pick(logic [N-1:0] req, int ptr);
        int best = -1, bdist = N;
        for (int i = 0; i < N; i++)
            if (req[i] && (i - ptr + N) % N < bdist) begin
                best = i;
                bdist = (i - ptr + N) % N;
            end
        return best;
    endfunction

    always @(negedge clk) if (n_rst) begin
        int e;
        exp_t x;
        cyc++;
        chk("busy_uniform", 256'(m_busy == '0 || m_busy == '1), 256'(1));
        if (s_en) begin
            e = rr_pick(en_prev, mptr);
            chk("grant_exists", 256'(e >= 0), 256'(1));
            if (e >= 0) begin
                chk("s_address", s_address, m_address[e*AW +: AW]);
                chk("s_data_out", s_data_out, m_data_out[e*DW +: DW]);
                chk("s_rnw", s_rnw, m_rnw[e]);
                issue_log.push_back(e);
                dout_log.push_back(s_data_out);
                mptr = (e + 1) % N;
                sb.push_back('{e, cur_resp, cur_lat});
            end
            inflight = 1;
            iss_addr = s_address;
            iss_dout = s_data_out;
            iss_rnw  = s_rnw;
            iss_cyc  = cyc;
        end else if (inflight)
            chk("hold", {s_address, s_data_out, s_rnw, s_en, m_busy}, {iss_addr, iss_dout, iss_rnw, 1'b0, {N{1'b1}}});
        if (m_data_valid != '0) begin
            done_cnt++;
            if (sb.size() == 0) chk("unexpected_done", 256'(m_data_valid), 256'(0));
            else begin
                x = sb.pop_front();
                model_data[x.idx] = x.data;
                chk("valid_onehot", 256'(m_data_valid), 256'(1) << x.idx);
                chk("latency", 256'(cyc - iss_cyc), 256'(x.lat));
                for (int i = 0; i < N; i++) chk("m_data_in", m_data_in[i*DW +: DW], model_data[i]);
            end
            inflight = 0;
        end
        en_prev = m_en;
    end

    task automatic set_req(int i, logic [AW-1:0] a, logic [DW-1:0] d, logic r);
        m_address[i*AW +: AW]  = a;
        m_data_out[i*DW +: DW] = d;
        m_rnw[i] = r;
        m_en[i]  = 1'b1;
    endtask

    // one clock: masters drop on completion, slave model responds, optional random requests
    task automatic tick();
        logic [N-1:0] done;
        int d;
        @(posedge clk);
        #1;
        done = m_data_valid;
        m_en = m_en & ~done;
        s_data_valid = 1'b0;
        if (s_en) begin
            d = fix_delay >= 0 ? fix_delay : int'($urandom_range(3));
            cur_resp = silent ? {DW{1'b1}} : fix_data ? fixed_val : DW'($urandom);
            cur_lat = silent ? TO + 1 : d + 2;
            sl_pending = !silent;
            sl_cnt = d;
        end else if (sl_pending) begin
            if (sl_cnt == 0) begin
                s_data_valid = 1'b1;
                s_data_in = cur_resp;
                sl_pending = 0;
            end else sl_cnt--;
        end else if (spur && $urandom_range(5) == 0) begin
            s_data_valid = 1'b1;
            s_data_in = DW'($urandom);
        end
        if (rand_req)
            for (int i = 0; i < N; i++)
                if (!m_en[i] && !done[i] && $urandom_range(4) == 0)
                    set_req(i, AW'($urandom), DW'($urandom), 1'($urandom));
    endtask

    task automatic drain(int budget);
        int n = 0;
        while ((m_en != '0 || inflight || sb.size() != 0) && n < budget) begin
            tick();
            n++;
        end
        chk("drain", 256'(m_en != '0 || inflight || sb.size() != 0), 256'(0));
    endtask

    task automatic do_reset();
        #2 n_rst = 1'b0;
        #1 chk("reset_out", {s_address, s_data_out, s_rnw, s_en, m_data_valid, m_busy, m_data_in}, '0);
        sb.delete();
        inflight = 0;
        mptr = 0;
        sl_pending = 0;
        silent = 0;
        spur = 0;
        s_data_valid = 1'b0;
        m_en = '0;
        en_prev = '0;
        foreach (model_data[i]) model_data[i] = '0;
        repeat (2) tick();
        n_rst = 1'b1;
    endtask

    initial begin
        int d0;
        foreach (model_data[i]) model_data[i] = '0;
        do_reset();
        fix_data = 1;
        fixed_val = 32'hDEADBEEF;
        fix_delay = 0;
        set_req(2, 32'h100, 32'h0, 1'b1);
        drain(20);
        chk("rd_data", m_data_in[2*DW +: DW], 32'hDEADBEEF);
        chk("rd_grant", 256'(issue_log.size() == 1 && issue_log[0] == 2), 256'(1));
        do_reset();
        issue_log.delete();
        dout_log.delete();
        fix_data = 0;
        fix_delay = -1;
        for (int i = 0; i < N; i++) set_req(i, AW'(32'h200 + 4 * i), DW'(32'hA0 + i), 1'b0);
        drain(60);
        chk("wr_count", 256'(issue_log.size()), 256'(4));
        for (int i = 0; i < issue_log.size() && i < 4; i++) begin
            chk("wr_order", 256'(issue_log[i]), 256'(i));
            chk("wr_data_seq", dout_log[i], DW'(32'hA0 + i));
        end
        issue_log.delete();
        set_req(1, 32'h300, 32'h11, 1'b1);
        drain(20);
        set_req(0, 32'h310, 32'h22, 1'b0);
        set_req(3, 32'h320, 32'h33, 1'b1);
        drain(40);
        chk("ptr_order", 256'(issue_log.size() == 3 && issue_log[1] == 3 && issue_log[2] == 0), 256'(1));
        issue_log.delete();
        fix_delay = LONG_DLY;
        set_req(0, 32'h400, 32'h44, 1'b1);
        repeat (3) tick();
        set_req(1, 32'h410, 32'h55, 1'b1);
        tick();
        m_en[1] = 1'b0;
        drain(40);
        fix_delay = -1;
        chk("dropped_req", 256'(issue_log.size() == 1 && issue_log[0] == 0), 256'(1));
        d0 = done_cnt;
        s_data_valid = 1'b1;
        s_data_in = 32'h12345678;
        repeat (5) tick();
        chk("spurious_idle", 256'(done_cnt), 256'(d0));
        spur = 1;
        rand_req = 1;
        repeat (400) tick();
        rand_req = 0;
        spur = 0;
        drain(200);
        silent = 1;
        set_req(2, 32'h500, 32'h66, 1'b1);
`ifdef BIU_ARB_TIMEOUT_EN
        drain(40);
        chk("timeout_data", m_data_in[2*DW +: DW], {DW{1'b1}});
`else
        d0 = done_cnt;
        repeat (300) tick();
        chk("no_timeout", 256'(done_cnt), 256'(d0));
        chk("still_busy", 256'(m_busy), 256'({N{1'b1}}));
        do_reset();
`endif
        silent = 0;
        set_req(2, 32'h600, 32'h77, 1'b0);
        drain(20);
        silent = 1;
        set_req(3, 32'h700, 32'h88, 1'b1);
        repeat (4) tick();
        d0 = done_cnt;
        do_reset();
        chk("abort_no_done", 256'(done_cnt), 256'(d0));
        issue_log.delete();
        set_req(1, 32'h800, 32'h99, 1'b1);
        set_req(3, 32'h810, 32'hAA, 1'b0);
        drain(40);
        chk("post_reset_order", 256'(issue_log.size() == 2 && issue_log[0] == 1 && issue_log[1] == 3), 256'(1));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end
endmodule
